// File: rtl/cpu_controller.sv
// Eight-phase fetch/execute sequencer for the 8-bit RISC CPU; decodes the IR opcode into datapath strobes.
// Optional feature macro: CTRL_RESUME_EN adds a `resume` input that releases the HALTED state.
module cpu_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  opcode,
  input  logic        zero,
`ifdef CTRL_RESUME_EN
  input  logic        resume,
`endif
  output logic        sel,
  output logic        rd,
  output logic        ld_ir,
  output logic        inc_pc,
  output logic        ld_pc,
  output logic        halt,
  output logic        data_e,
  output logic        ld_ac,
  output logic        wr,
  output logic [2:0]  phase,
  output logic [15:0] instr_count
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned PHASE_W = 3;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  // HALTED sits outside the 3-bit phase space so it cannot alias OP_ADDR internally.
  typedef enum logic [3:0] {
    S_INST_ADDR  = 4'd0,
    S_INST_FETCH = 4'd1,
    S_INST_LOAD  = 4'd2,
    S_IDLE       = 4'd3,
    S_OP_ADDR    = 4'd4,
    S_OP_FETCH   = 4'd5,
    S_ALU_OP     = 4'd6,
    S_STORE      = 4'd7,
    S_HALTED     = 4'd8
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;

  logic is_aluop;
  logic is_hlt;
  logic is_skz;
  logic is_sto;
  logic is_jmp;

  always_comb begin
    is_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
               (opcode == OP_XOR) || (opcode == OP_LDA);
    is_hlt   = (opcode == OP_HLT);
    is_skz   = (opcode == OP_SKZ);
    is_sto   = (opcode == OP_STO);
    is_jmp   = (opcode == OP_JMP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_INST_ADDR;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Next state: linear walk through the eight phases, HLT diverts to HALTED.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INST_ADDR:  state_d = S_INST_FETCH;
      S_INST_FETCH: state_d = S_INST_LOAD;
      S_INST_LOAD:  state_d = S_IDLE;
      S_IDLE:       state_d = S_OP_ADDR;
      S_OP_ADDR:    state_d = is_hlt ? S_HALTED : S_OP_FETCH;
      S_OP_FETCH:   state_d = S_ALU_OP;
      S_ALU_OP:     state_d = S_STORE;
      S_STORE:      state_d = S_INST_ADDR;
      S_HALTED: begin
`ifdef CTRL_RESUME_EN
        if (resume) state_d = S_INST_ADDR;
`endif
      end
      default:      state_d = S_INST_ADDR;
    endcase
  end

  // Retirement counter ticks on the edge that leaves STORE; wraps naturally.
  always_comb begin
    instr_count_d = instr_count_q;
    if (state_q == S_STORE) instr_count_d = instr_count_q + CNT_W'(1);
  end

  // Strobe decode: Moore on state, qualified by opcode and zero.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    halt   = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    unique case (state_q)
      S_INST_ADDR: begin
        sel = 1'b1;
      end
      S_INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      S_INST_LOAD, S_IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      S_OP_ADDR: begin
        inc_pc = 1'b1;
        halt   = is_hlt;
      end
      S_OP_FETCH: begin
        rd = is_aluop;
      end
      S_ALU_OP: begin
        rd     = is_aluop;
        inc_pc = is_skz && zero;
        ld_pc  = is_jmp;
        data_e = is_sto;
      end
      S_STORE: begin
        rd     = is_aluop;
        inc_pc = is_jmp;
        ld_pc  = is_jmp;
        ld_ac  = is_aluop;
        wr     = is_sto;
        data_e = is_sto;
      end
      S_HALTED: begin
        halt = 1'b1;
      end
      default: begin
        sel = 1'b1;
      end
    endcase
  end

  always_comb begin
    phase = (state_q == S_HALTED) ? 3'b100 : PHASE_W'(state_q);
  end

  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: stimulus queues hand-computed output vectors, a negedge monitor compares.
// Honours CTRL_RESUME_EN when defined for the build.
module tb_cpu_controller;

  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  logic        clk;
  logic        rst;
  logic [2:0]  opcode;
  logic        zero;
`ifdef CTRL_RESUME_EN
  logic        resume;
`endif
  logic        sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr;
  logic [2:0]  phase;
  logic [15:0] instr_count;

  cpu_controller dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .zero        (zero),
`ifdef CTRL_RESUME_EN
    .resume      (resume),
`endif
    .sel         (sel),
    .rd          (rd),
    .ld_ir       (ld_ir),
    .inc_pc      (inc_pc),
    .ld_pc       (ld_pc),
    .halt        (halt),
    .data_e      (data_e),
    .ld_ac       (ld_ac),
    .wr          (wr),
    .phase       (phase),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: {phase, sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr, instr_count}
  typedef struct {
    string       name;
    logic [27:0] v;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec  = 0;
  int          n_fail = 0;
  logic [15:0] cnt;

  function automatic logic [27:0] mk(input logic [2:0] ph, input logic [8:0] bits, input logic [15:0] c);
    return {ph, bits, c};
  endfunction

  function automatic logic [27:0] act_vec();
    return {phase, sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr, instr_count};
  endfunction

  function automatic void check(input string nm, input logic [27:0] act, input logic [27:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got ph=%0d strb=%b cnt=%h, expected ph=%0d strb=%b cnt=%h",
               nm, act[27:25], act[24:16], act[15:0], req[27:25], req[24:16], req[15:0]);
    end
  endfunction

  task automatic push(input string nm, input logic [27:0] v);
    exp_t e;
    e.name = nm;
    e.v    = v;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(e.name, act_vec(), e.v);
    end
  end

  // One full instruction starting at posedge+1 in INST_ADDR; opcode pre_op until IDLE.
  task automatic run_instr(input string nm, input logic [2:0] pre_op, input logic [2:0] op, input logic z,
                           input logic [7:0] rd_m, input logic [7:0] inc_m, input logic [7:0] ldpc_m,
                           input logic [7:0] de_m, input logic [7:0] ldac_m, input logic [7:0] wr_m,
                           input bit rel_force);
    logic [7:0] sel_m;
    logic [7:0] ldir_m;
    sel_m  = 8'h0F;
    ldir_m = 8'h0C;
    zero   = z;
    for (int p = 0; p < 8; p++) begin
      opcode = (p < 3) ? pre_op : op;
      push($sformatf("%s_p%0d", nm, p),
           mk(3'(p), {sel_m[p], rd_m[p], ldir_m[p], inc_m[p], ldpc_m[p], 1'b0, de_m[p], ldac_m[p], wr_m[p]}, cnt));
      if (rel_force && p == 1) release dut.instr_count_q;
      @(posedge clk); #1;
    end
    cnt = cnt + 16'd1;
  endtask

  task automatic apply_reset(input string nm);
    rst = 1'b1;
    #1;
    check(nm, act_vec(), mk(3'd0, 9'b1_0000_0000, 16'h0000));
    cnt = 16'h0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench still running at %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    rst    = 1'b1;
    opcode = ADD;
    zero   = 1'b0;
    cnt    = 16'h0000;
`ifdef CTRL_RESUME_EN
    resume = 1'b0;
`endif
    @(posedge clk); #1;
    apply_reset("reset");

    run_instr("add",    ADD, ADD, 1'b0, 8'hEE, 8'h10, 8'h00, 8'h00, 8'h80, 8'h00, 1'b0);
    run_instr("sto",    STO, STO, 1'b0, 8'h0E, 8'h10, 8'h00, 8'hC0, 8'h00, 8'h80, 1'b0);
    run_instr("skz_z1", SKZ, SKZ, 1'b1, 8'h0E, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    run_instr("skz_z0", SKZ, SKZ, 1'b0, 8'h0E, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    run_instr("jmp",    JMP, JMP, 1'b1, 8'h0E, 8'h90, 8'hC0, 8'h00, 8'h00, 8'h00, 1'b0);
    // Opcode toggling before IDLE must not disturb the fetch phases.
    run_instr("lda_late", HLT, LDA, 1'b1, 8'hEE, 8'h10, 8'h00, 8'h00, 8'h80, 8'h00, 1'b0);

    // HLT: halts on the 5th edge and freezes.
    opcode = HLT;
    zero   = 1'b0;
    for (int p = 0; p < 4; p++) begin
      push($sformatf("hlt_p%0d", p),
           mk(3'(p), (p == 0) ? 9'b1_0000_0000 : (p == 1) ? 9'b1_1000_0000 : 9'b1_1100_0000, cnt));
      @(posedge clk); #1;
    end
    push("hlt_opaddr", mk(3'd4, 9'b0_0010_1000, cnt));
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      opcode = 3'(i);
      zero   = i[0];
      push($sformatf("halted_%0d", i), mk(3'd4, 9'b0_0000_1000, cnt));
      @(posedge clk); #1;
    end
`ifdef CTRL_RESUME_EN
    resume = 1'b1;
    push("resume_pulse", mk(3'd4, 9'b0_0000_1000, cnt));
    @(posedge clk); #1;
    resume = 1'b0;
    run_instr("after_resume", ADD, ADD, 1'b0, 8'hEE, 8'h10, 8'h00, 8'h00, 8'h80, 8'h00, 1'b0);
`else
    apply_reset("reset_from_halt");
    run_instr("after_halt_rst", ADD, ADD, 1'b0, 8'hEE, 8'h10, 8'h00, 8'h00, 8'h80, 8'h00, 1'b0);
`endif

    // Async reset in ALU_OP of a STO: data_e must drop without a clock edge.
    opcode = STO;
    for (int p = 0; p < 7; p++) begin
      push($sformatf("abort_p%0d", p),
           mk(3'(p), (p == 0) ? 9'b1_0000_0000 : (p == 1) ? 9'b1_1000_0000 :
                     (p < 4)  ? 9'b1_1100_0000 : (p == 4) ? 9'b0_0010_0000 :
                     (p == 5) ? 9'b0_0000_0000 : 9'b0_0000_0100, cnt));
      if (p < 6) begin
        @(posedge clk); #1;
      end
    end
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("async_rst", act_vec(), mk(3'd0, 9'b1_0000_0000, 16'h0000));
    cnt = 16'h0000;
    @(posedge clk); #1;
    check("rst_hold_no_wr", act_vec(), mk(3'd0, 9'b1_0000_0000, 16'h0000));
    rst = 1'b0;
    run_instr("post_abort", XOR, XOR, 1'b0, 8'hEE, 8'h10, 8'h00, 8'h00, 8'h80, 8'h00, 1'b0);

    // Counter wrap: preload 0xFFFF, next retirement reads 0x0000.
    force dut.instr_count_q = 16'hFFFF;
    cnt = 16'hFFFF;
    run_instr("wrap", ADD, ADD, 1'b0, 8'hEE, 8'h10, 8'h00, 8'h00, 8'h80, 8'h00, 1'b1);
    run_instr("post_wrap", STO, STO, 1'b0, 8'h0E, 8'h10, 8'h00, 8'hC0, 8'h00, 8'h80, 1'b0);
    push("final_cnt", mk(3'd0, 9'b1_0000_0000, cnt));

    @(negedge clk); #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected vectors left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
